// File: rtl/pattern_seq_pkg.sv
// Shared constants and state encoding for the pattern sequence controller.
package pattern_seq_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int LEN_W     = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/pattern_sequence_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over inc.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;

  // next count: clear, or step unless already at all-ones
  always_comb begin
    count_d = count_q;
    if (clear)                  count_d = '0;
    else if (inc && ~&count_q)  count_d = count_q + 1'b1;
  end

  // count register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/pattern_sequence_controller.sv
// Pattern sequence controller: captures a stimulus word, shifts it out
// LSB-first one bit per tick, and counts Moore/Mealy detections sampled the
// cycle after each shift.
// Optional build macro PATTERN_SEQ_LOOP_EN: DONE re-enters LOAD forever
// (busy held high, start ignored after the first pass) until reset.
module pattern_sequence_controller
  import pattern_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  output logic             shift_en,
  output logic             shift_in,
  input  logic             detect_moore,
  input  logic             detect_mealy,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bit_index,
  output logic [CNT_W-1:0] moore_count,
  output logic [CNT_W-1:0] mealy_count
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic             samp_q;
  logic             cnt_clr;
  logic [LEN_W-1:0] eff_len;

  // 0 and anything above WIDTH both mean a full-width sequence
  assign eff_len = (length == '0 || int'(length) > WIDTH) ? LEN_W'(WIDTH) : length;

  // next-state, datapath updates and strobes
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    idx_d    = idx_q;
    shift_en = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD: begin
        pat_d   = pattern;
        len_d   = eff_len;
        idx_d   = '0;
        cnt_clr = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: if (tick) begin
        shift_en = 1'b1;
        pat_d    = pat_q >> 1;
        idx_d    = idx_q + 1'b1;
        if (idx_q + 1'b1 == len_q) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
`ifdef PATTERN_SEQ_LOOP_EN
      S_DONE:  state_d = S_LOAD;
`else
      S_DONE:  state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // state, pattern, length, bit counter and detection sample-delay flop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      samp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      samp_q  <= shift_en;
    end
  end

  assign shift_in  = shift_en & pat_q[0];
  assign done      = (state_q == S_DONE);
  assign bit_index = idx_q;
`ifdef PATTERN_SEQ_LOOP_EN
  assign busy = (state_q != S_IDLE);
`else
  assign busy = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_DRAIN);
`endif

  sat_counter #(.CNT_W(CNT_W)) u_moore_cnt (
    .clock(clock), .reset(reset), .clear(cnt_clr),
    .inc(samp_q & detect_moore), .count(moore_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mealy_cnt (
    .clock(clock), .reset(reset), .clear(cnt_clr),
    .inc(samp_q & detect_mealy), .count(mealy_count)
  );
endmodule

// File: tb/tb_pattern_sequence_controller.sv
// Self-checking bench: table vectors plus random sequences checked against a
// transaction-level model (bit order, tick timing, detection counts).
module tb_pattern_sequence_controller;
  logic        clock = 1'b0;
  logic        reset, tick, start, detect_moore, detect_mealy;
  logic [15:0] pattern;
  logic [4:0]  length;
  logic        shift_en, shift_in, busy, done;
  logic [4:0]  bit_index;
  logic [7:0]  moore_count, mealy_count;
  logic        s_shift_en, s_shift_in, s_busy, s_done;
  logic [4:0]  s_bit_index;
  logic [1:0]  s_moore_count, s_mealy_count;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pattern_sequence_controller #(.WIDTH(16), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .tick(tick), .start(start), .pattern(pattern),
    .length(length), .shift_en(shift_en), .shift_in(shift_in),
    .detect_moore(detect_moore), .detect_mealy(detect_mealy), .busy(busy),
    .done(done), .bit_index(bit_index), .moore_count(moore_count),
    .mealy_count(mealy_count)
  );

  pattern_sequence_controller #(.WIDTH(16), .CNT_W(2)) dut_s (
    .clock(clock), .reset(reset), .tick(tick), .start(start), .pattern(pattern),
    .length(length), .shift_en(s_shift_en), .shift_in(s_shift_in),
    .detect_moore(detect_moore), .detect_mealy(detect_mealy), .busy(s_busy),
    .done(s_done), .bit_index(s_bit_index), .moore_count(s_moore_count),
    .mealy_count(s_mealy_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  typedef struct {
    logic [15:0] pat;
    logic [4:0]  len;
    int          gap;    // tick when cycle%gap==0; 0 = random ticks
    int          mmode;  // moore: 0 tied low, 1 tied high, 2 random
    logic [15:0] mmask;  // mealy high after bit k+1 when mmask[k]
    int          exp_bits; // -1: no table expectations
    int          exp_m8, exp_m2, exp_l8, exp_l2;
  } vec_t;

  // One sequence from IDLE to one cycle past done, checked every cycle.
  task automatic run_seq(input vec_t v, input string tag);
    int eff, nsh, last, em, el;
    bit prev, tk, exp_sh, exp_busy, exp_done, fin;
    eff  = (v.len == 0 || v.len > 16) ? 16 : int'(v.len);
    nsh = 0; last = -1; em = 0; el = 0; prev = 0; fin = 0;
    for (int c = 0; c < 600 && !fin; c++) begin
      tk    = (v.gap == 0) ? 1'($urandom % 2) : (c % v.gap == 0);
      tick  = tk;
      start = (c == 0) ? 1'b1 : ((last >= 0) ? 1'b0 : 1'($urandom % 2));
      pattern = (c <= 1) ? v.pat : 16'($urandom);
      length  = (c <= 1) ? v.len : 5'($urandom);
      detect_moore = (v.mmode == 0) ? 1'b0 : (v.mmode == 1) ? 1'b1 : 1'($urandom % 2);
      detect_mealy = prev ? v.mmask[nsh-1] : 1'($urandom % 2);
      @(negedge clock);
      exp_sh   = (c >= 2) && tk && (nsh < eff);
      exp_busy = (c >= 1) && (last < 0 || c <= last + 1);
      exp_done = (last >= 0) && (c == last + 2);
      chk({tag, " shift_en"}, shift_en, exp_sh);
      if (exp_sh) chk({tag, " shift_in"}, shift_in, v.pat[nsh]);
      chk({tag, " busy"}, busy, exp_busy);
      chk({tag, " done"}, done, exp_done);
      if (c >= 2) begin
        chk({tag, " bit_index"}, bit_index, nsh);
        chk({tag, " moore_count"}, moore_count, sat(em, 255));
        chk({tag, " mealy_count"}, mealy_count, sat(el, 255));
        chk({tag, " moore_count_w2"}, s_moore_count, sat(em, 3));
        chk({tag, " mealy_count_w2"}, s_mealy_count, sat(el, 3));
      end
      if (exp_done) begin
        fin = 1;
        if (v.exp_bits >= 0) begin
          chk({tag, " final bit_index"}, bit_index, v.exp_bits);
          chk({tag, " final moore8"}, moore_count, v.exp_m8);
          chk({tag, " final moore2"}, s_moore_count, v.exp_m2);
          chk({tag, " final mealy8"}, mealy_count, v.exp_l8);
          chk({tag, " final mealy2"}, s_mealy_count, v.exp_l2);
        end
      end
      if (prev && detect_moore) em++;
      if (prev && detect_mealy) el++;
      prev = exp_sh;
      if (exp_sh) begin
        nsh++;
        if (nsh == eff) last = c;
      end
      @(posedge clock); #1;
    end
    if (!fin) chk({tag, " timeout waiting for done"}, 0, 1);
    // back in IDLE: ticks must not shift, no stray done
    tick = 1'b1; start = 1'b0;
    @(negedge clock);
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " idle done"}, done, 0);
    chk({tag, " idle shift_en"}, shift_en, 0);
    @(posedge clock); #1;
  endtask

  vec_t tbl[6];
  vec_t rv;
  int   dones;

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0; pattern = '0; length = '0;
    detect_moore = 1'b0; detect_mealy = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst shift_en", shift_en, 0);
    chk("rst shift_in", shift_in, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst bit_index", bit_index, 0);
    chk("rst moore_count", moore_count, 0);
    chk("rst mealy_count", mealy_count, 0);
    reset = 1'b0;
    @(posedge clock); #1;

`ifdef PATTERN_SEQ_LOOP_EN
    // loop mode: three passes of length 4, busy never drops, counters clear per pass
    pattern = 16'h000A; length = 5'd4; tick = 1'b1; detect_moore = 1'b1; start = 1'b1;
    dones = 0;
    for (int c = 0; c < 80 && dones < 3; c++) begin
      @(negedge clock);
      if (c >= 1) chk("loop busy", busy, 1);
      if (done) begin
        dones++;
        chk("loop moore_count", moore_count, 4);
        chk("loop bit_index", bit_index, 4);
      end
      @(posedge clock); #1;
      start = 1'($urandom % 2);
    end
    chk("loop done pulses", dones, 3);
`else
    tbl[0] = '{16'hABCD, 5'd16, 4, 0, 16'h0000, 16, 0, 0, 0, 0};
    tbl[1] = '{16'h1234, 5'd0,  1, 1, 16'h0012, 16, 16, 3, 2, 2};
    tbl[2] = '{16'h0005, 5'd3,  2, 1, 16'h0007, 3, 3, 3, 3, 3};
    tbl[3] = '{16'hFFFF, 5'd20, 1, 0, 16'hFFFF, 16, 0, 0, 16, 3};
    tbl[4] = '{16'h8001, 5'd1,  3, 1, 16'h0001, 1, 1, 1, 1, 1};
    tbl[5] = '{16'h0000, 5'd17, 1, 1, 16'h0000, 16, 16, 3, 0, 0};
    for (int i = 0; i < 6; i++) run_seq(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      rv = '{16'($urandom), 5'($urandom), int'($urandom % 4), 2, 16'($urandom), -1, 0, 0, 0, 0};
      run_seq(rv, $sformatf("rnd%0d", i));
    end

    // start held through DONE re-enters LOAD right after the IDLE cycle
    pattern = 16'h0001; length = 5'd1; tick = 1'b1; start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (c == 4) begin chk("held done", done, 1); chk("held busy@done", busy, 0); end
      if (c == 5) begin chk("held idle busy", busy, 0); chk("held idle done", done, 0); end
      if (c == 6) chk("held reload busy", busy, 1);
      if (c == 7) chk("held reshift", shift_en, 1);
      @(posedge clock); #1;
    end
    start = 1'b0;
    dones = 0;
    for (int c = 0; c < 10 && dones == 0; c++) begin
      @(negedge clock);
      if (done) dones = 1;
      @(posedge clock); #1;
    end
    chk("held second done", dones, 1);

    // reset in the middle of SHIFT aborts without a done pulse
    pattern = 16'hABCD; length = 5'd16; tick = 1'b1; detect_moore = 1'b1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("pre-reset shift_en", shift_en, 1);
    reset = 1'b1; #1;
    chk("mid rst shift_en", shift_en, 0);
    chk("mid rst shift_in", shift_in, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst done", done, 0);
    chk("mid rst bit_index", bit_index, 0);
    chk("mid rst moore_count", moore_count, 0);
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (done || busy || shift_en) dones++;
    end
    chk("post rst idle activity", dones, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
